// File: rtl/dimension_swap.sv
// Transposes an N-entry array of W-bit vectors into a W-entry array of N-bit vectors.
// It provides a pure-wire view and a registered, valid-qualified copy.
module dimension_swap #(
    parameter int INPUT_UNPACKED_SIZE = 2,
    parameter int INPUT_PACKED_SIZE   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [INPUT_PACKED_SIZE-1:0]   in        [INPUT_UNPACKED_SIZE],
    input  logic                           in_valid,
    output logic [INPUT_UNPACKED_SIZE-1:0] out       [INPUT_PACKED_SIZE],
    output logic [INPUT_UNPACKED_SIZE-1:0] out_q     [INPUT_PACKED_SIZE],
    output logic                           out_valid
);
    localparam int N = INPUT_UNPACKED_SIZE;
    localparam int W = INPUT_PACKED_SIZE;

    generate
        if (N < 1) begin : g_bad_n
            $error("dimension_swap: INPUT_UNPACKED_SIZE must be >= 1");
        end
        if (W < 1) begin : g_bad_w
            $error("dimension_swap: INPUT_PACKED_SIZE must be >= 1");
        end
    endgenerate

    logic [N-1:0] out_q_reg [W];
    logic         out_valid_reg;

    // Entry j of in lands at bit j of every output entry.
    genvar gi, gj;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            for (gj = 0; gj < N; gj++) begin : g_entry
                assign out[gi][gj] = in[gj][gi];
            end
            assign out_q[gi] = out_q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                out_q_reg[i] <= '0;
            end
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < W; i++) begin
                    out_q_reg[i] <= out[i];
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_dimension_swap.sv
// Directed bench for dimension_swap across several array shapes.
module tb_dimension_swap;
    logic clk;
    logic reset;
    logic in_valid;

    logic [3:0] in_a    [2];
    logic [1:0] out_a   [4];
    logic [1:0] out_q_a [4];
    logic       out_valid_a;

    logic [4:0] in_b    [3];
    logic [2:0] out_b   [5];
    logic [2:0] out_q_b [5];
    logic       out_valid_b;

    logic [0:0] in_c    [1];
    logic [0:0] out_c   [1];
    logic [0:0] out_q_c [1];
    logic       out_valid_c;

    logic [0:0] in_d    [4];
    logic [3:0] out_d   [1];
    logic [3:0] out_q_d [1];
    logic       out_valid_d;

    int checks = 0;
    int fails  = 0;

    dimension_swap #(.INPUT_UNPACKED_SIZE(2), .INPUT_PACKED_SIZE(4)) dut_a (
        .clk(clk), .reset(reset), .in(in_a), .in_valid(in_valid),
        .out(out_a), .out_q(out_q_a), .out_valid(out_valid_a));
    dimension_swap #(.INPUT_UNPACKED_SIZE(3), .INPUT_PACKED_SIZE(5)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .in_valid(in_valid),
        .out(out_b), .out_q(out_q_b), .out_valid(out_valid_b));
    dimension_swap #(.INPUT_UNPACKED_SIZE(1), .INPUT_PACKED_SIZE(1)) dut_c (
        .clk(clk), .reset(reset), .in(in_c), .in_valid(in_valid),
        .out(out_c), .out_q(out_q_c), .out_valid(out_valid_c));
    dimension_swap #(.INPUT_UNPACKED_SIZE(4), .INPUT_PACKED_SIZE(1)) dut_d (
        .clk(clk), .reset(reset), .in(in_d), .in_valid(in_valid),
        .out(out_d), .out_q(out_q_d), .out_valid(out_valid_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        if (observed === expected) $display("[%0t] ok %s = %h", $time, tag, observed);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_v;
        logic [1:0]  exp_a [4];

        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '{4'h0, 4'h0};
        in_b = '{5'h0, 5'h0, 5'h0};
        in_c = '{1'b0};
        in_d = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        tick();
        for (int i = 0; i < 4; i++) check($sformatf("reset_out_q_a[%0d]", i), 32'(out_q_a[i]), 32'h0);
        check("reset_out_valid_a", 32'(out_valid_a), 32'h0);
        reset = 1'b0;

        // Vector 1: in[0]=0000, in[1]=1111 -> every out entry 2'b10
        in_a[0] = 4'b0000;
        in_a[1] = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("v1_out_a[%0d]", i), 32'(out_a[i]), 32'h2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) check($sformatf("v1_out_q_a[%0d]", i), 32'(out_q_a[i]), 32'h2);
        check("v1_out_valid_a", 32'(out_valid_a), 32'h1);

        // Vector 2: in[0]=1010, in[1]=0110
        in_a[0] = 4'b1010;
        in_a[1] = 4'b0110;
        exp_a = '{2'b00, 2'b11, 2'b10, 2'b01};
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("v2_out_a[%0d]", i), 32'(out_a[i]), 32'(exp_a[i]));
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) check($sformatf("v2_out_q_a[%0d]", i), 32'(out_q_a[i]), 32'(exp_a[i]));

        // Hold: drop in_valid and change in; out_q keeps the old transpose
        in_valid = 1'b0;
        in_a[0] = 4'b0000;
        in_a[1] = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("hold_out_a[%0d]", i), 32'(out_a[i]), 32'h2);
        tick();
        for (int i = 0; i < 4; i++) check($sformatf("hold_out_q_a[%0d]", i), 32'(out_q_a[i]), 32'(exp_a[i]));
        check("hold_out_valid_a", 32'(out_valid_a), 32'h0);

        // Reset wins over in_valid with nonzero in
        in_valid = 1'b1;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) check($sformatf("rst_out_q_a[%0d]", i), 32'(out_q_a[i]), 32'h0);
        check("rst_out_valid_a", 32'(out_valid_a), 32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_live_out_a[%0d]", i), 32'(out_a[i]), 32'h2);
        reset = 1'b0;
        in_valid = 1'b0;

        // Walking one over N=3, W=5
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 5; i++) begin
                in_b = '{5'h0, 5'h0, 5'h0};
                in_b[j][i] = 1'b1;
                #1;
                for (int k = 0; k < 5; k++) begin
                    exp_v = 32'h0;
                    if (k == i) exp_v[j] = 1'b1;
                    check($sformatf("walk_in[%0d][%0d]_out_b[%0d]", j, i, k), 32'(out_b[k]), exp_v);
                end
            end
        end

        // Degenerate shapes
        in_c[0] = 1'b1;
        in_d[0] = 1'b1;
        in_d[1] = 1'b0;
        in_d[2] = 1'b1;
        in_d[3] = 1'b1;
        #1;
        check("n1w1_out_c", 32'(out_c[0]), 32'h1);
        check("n4w1_out_d", 32'(out_d[0]), 32'hd);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("n4w1_out_q_d", 32'(out_q_d[0]), 32'hd);
        check("n4w1_out_valid_d", 32'(out_valid_d), 32'h1);
        check("n1w1_out_q_c", 32'(out_q_c[0]), 32'h1);
        in_c[0] = 1'b0;
        #1;
        check("n1w1_out_c_zero", 32'(out_c[0]), 32'h0);
        tick();
        check("n1w1_out_valid_c_drop", 32'(out_valid_c), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
